ula_arbiter: RTL and testbench
==============================

# ula_arbiter

Sequencer and two-port arbiter for the shared combinational ALU (ULAS). It accepts operation requests from two requesters over valid/ready handshakes, grants one at a time with round-robin fairness, and holds the captured operands stable on the ALU inputs for the required number of cycles. Single-cycle operations hold for one cycle; multiply and divide hold for a configurable latency. It then registers the ALU result and flag and returns them to the owning requester as a one-cycle response pulse.

## Interface
- MULDIV_LAT, 4, cycles operands are held on the ALU for aluop 5'b10000 (mult) and 5'b10001 (div); legal range 1..16
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op1, req0_op2  in  32  operands
- req0_smt  in  5  shift amount
- req0_aluop  in  5  ALU operation code
- rsp0_valid  out  1  one-cycle pulse: result for requester 0
- rsp0_r1  out  32  result word
- rsp0_uf  out  1  ALU flag (overflow or compare result)
- req1_* / rsp1_*: identical set for requester 1
- alu_op1, alu_op2  out  32  to shared ALU
- alu_smt  out  5  to shared ALU
- alu_aluop  out  5  to shared ALU
- alu_r1  in  32  from shared ALU
- alu_uf  in  1  from shared ALU
- busy  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- Registers:
  - prio (favoured requester)
  - owner
  - op1/op2/smt/aluop latch
  - cnt (4 bits)
  - result r1/uf
- IDLE, grant selection:
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant prio.
- IDLE, handshake:
  - reqN_ready = (state==IDLE) & grant==N & reqN_valid. It is combinational and is never high for both requesters.
  - On handshake: latch reqN operands, owner←N.
  - cnt←MULDIV_LAT-1 if aluop is 10000 or 10001, else 0.
  - Go to EXEC.
- EXEC:
  - If cnt==0: capture alu_r1/alu_uf into result registers and go to RESP.
  - Otherwise cnt←cnt-1.
- RESP:
  - rsp{owner}_valid=1 for exactly this cycle; rsp_r1/rsp_uf show the result registers.
  - prio←~owner; go to IDLE.
- alu_* outputs are driven directly from the operand latch in every state. They change only on a handshake.
- rspN_r1/rspN_uf hold the last result registers at all times. Only rsp{owner}_valid qualifies them. The non-owner rsp_valid stays 0.
- Responses have no back-pressure; requesters must accept the rsp pulse.
- Requester rule: once reqN_valid is raised, operands stay stable until reqN_ready. Dropping valid before the grant withdraws the request with no side effect.
- The arbiter does not interpret the ALU function; the aluop decode is only for the mult/div latency.

## Timing
- Reset (rst high at an edge):
  - state=IDLE, prio=0, owner=0, cnt=0.
  - Operand latch and result registers 0, so alu_* = 0 and rspN_r1=0, rspN_uf=0.
  - rspN_valid=0, busy=0.
- Reset in EXEC or RESP aborts the operation: no response is issued and no prio update occurs.
- Handshake in cycle T:
  - Single-cycle op: EXEC at T+1, result captured at the end of T+1, rsp_valid in T+2.
  - Mult/div: EXEC spans T+1..T+MULDIV_LAT, rsp_valid in T+MULDIV_LAT+1.
- Earliest next handshake is T+3 for single-cycle ops (T+MULDIV_LAT+2 for mult/div). Peak throughput is one single-cycle op per 3 cycles.
- alu_* stay constant from T+1 through the RESP cycle.
- A request arriving during EXEC/RESP waits. No ready is issued outside IDLE.
- Simultaneous valids after reset: requester 0 is served first.
- With both requesters continuously valid, grants strictly alternate.

## Test plan
- Single add: req0 op1=5, op2=7, aluop=00001, handshake at T -> rsp0_valid only in T+2, rsp0_r1=12, rsp0_uf=0, rsp1_valid stays 0.
- Overflow flag: req1 op1=32'h7FFFFFFF, op2=1, aluop=00001 -> rsp1_r1=32'h80000000, rsp1_uf=1. Also: op1=3, op2=9, aluop=01001 -> r1=0, uf=1.
- Arbitration: both valid from the first post-reset cycle, each re-raising valid after its response -> grant order 0,1,0,1. No cycle has both readies high.
- Mult latency (MULDIV_LAT=4): req0 op1=6, op2=7, aluop=10000 at T -> alu_aluop=10000 held over T+1..T+5, busy high T+1..T+5, rsp0_valid in T+5 with r1=42. A req1 raised at T+2 is readied at T+6.
- Reset mid-op: div accepted, rst high in the second EXEC cycle -> no rsp pulse, busy=0 and alu_op1=0 after reset. With a pending req1 and rst released at R, req1_ready=1 in cycle R.
- Withdrawn request: req1 valid during req0's EXEC, then deasserted before IDLE -> no req1_ready, no rsp1_valid, prio unaffected.

Source files
------------

// File: rtl/ula_arbiter.sv
// Two-port round-robin sequencer for the shared combinational ALU.
// Holds latched operands on the ALU for 1 or MULDIV_LAT cycles and returns a one-cycle response.
module ula_arbiter #(
  parameter int MULDIV_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_op1,
  input  logic [31:0] req0_op2,
  input  logic [4:0]  req0_smt,
  input  logic [4:0]  req0_aluop,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_r1,
  output logic        rsp0_uf,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_op1,
  input  logic [31:0] req1_op2,
  input  logic [4:0]  req1_smt,
  input  logic [4:0]  req1_aluop,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_r1,
  output logic        rsp1_uf,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [4:0]  alu_smt,
  output logic [4:0]  alu_aluop,
  input  logic [31:0] alu_r1,
  input  logic        alu_uf,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is accepted in a cycle where reqN_valid and reqN_ready are
  // both high; ready is only offered in IDLE and only to the granted requester.
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] MD_CNT = 4'(MULDIV_LAT - 1);

  state_t      state;
  logic        prio;
  logic        owner;
  logic        grant;
  logic [3:0]  cnt;
  logic [31:0] r1_q;
  logic        uf_q;
  logic [31:0] sel_op1;
  logic [31:0] sel_op2;
  logic [4:0]  sel_smt;
  logic [4:0]  sel_aluop;
  logic        sel_md;

  always_comb begin
    grant      = (req0_valid & req1_valid) ? prio : req1_valid;
    req0_ready = (state == IDLE) & req0_valid & ~grant;
    req1_ready = (state == IDLE) & req1_valid & grant;
    sel_op1    = grant ? req1_op1   : req0_op1;
    sel_op2    = grant ? req1_op2   : req0_op2;
    sel_smt    = grant ? req1_smt   : req0_smt;
    sel_aluop  = grant ? req1_aluop : req0_aluop;
    // Only mult (10000) and div (10001) need the long hold.
    sel_md     = (sel_aluop[4:1] == 4'b1000);
  end

  assign rsp0_r1   = r1_q;
  assign rsp1_r1   = r1_q;
  assign rsp0_uf   = uf_q;
  assign rsp1_uf   = uf_q;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prio       <= 1'b0;
      owner      <= 1'b0;
      cnt        <= 4'd0;
      alu_op1    <= 32'd0;
      alu_op2    <= 32'd0;
      alu_smt    <= 5'd0;
      alu_aluop  <= 5'd0;
      r1_q       <= 32'd0;
      uf_q       <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_ready | req1_ready) begin
            alu_op1   <= sel_op1;
            alu_op2   <= sel_op2;
            alu_smt   <= sel_smt;
            alu_aluop <= sel_aluop;
            owner     <= grant;
            cnt       <= sel_md ? MD_CNT : 4'd0;
            state     <= EXEC;
            busy      <= 1'b1;
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            r1_q       <= alu_r1;
            uf_q       <= alu_uf;
            rsp0_valid <= ~owner;
            rsp1_valid <= owner;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          prio  <= ~owner;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed bench for ula_arbiter: reset, single ops, flags, arbitration, mult latency,
// reset abort and withdrawn requests, with a small stand-in ALU on the shared port.
module tb_ula_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
  logic [4:0]  req0_smt = '0, req0_aluop = '0, req1_smt = '0, req1_aluop = '0;
  logic        rsp0_valid, rsp1_valid, rsp0_uf, rsp1_uf;
  logic [31:0] rsp0_r1, rsp1_r1;
  logic [31:0] alu_op1, alu_op2, alu_r1;
  logic [4:0]  alu_smt, alu_aluop;
  logic        alu_uf;
  logic        busy;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  ula_arbiter #(.MULDIV_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req0_smt(req0_smt), .req0_aluop(req0_aluop),
    .rsp0_valid(rsp0_valid), .rsp0_r1(rsp0_r1), .rsp0_uf(rsp0_uf),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1), .req1_op2(req1_op2),
    .req1_smt(req1_smt), .req1_aluop(req1_aluop),
    .rsp1_valid(rsp1_valid), .rsp1_r1(rsp1_r1), .rsp1_uf(rsp1_uf),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_smt(alu_smt), .alu_aluop(alu_aluop),
    .alu_r1(alu_r1), .alu_uf(alu_uf), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: add with signed overflow, signed less-than, mult, div.
  logic [31:0] sum;
  always_comb begin
    sum    = alu_op1 + alu_op2;
    alu_r1 = 32'd0;
    alu_uf = 1'b0;
    case (alu_aluop)
      5'b00001: begin
        alu_r1 = sum;
        alu_uf = (alu_op1[31] == alu_op2[31]) && (sum[31] != alu_op1[31]);
      end
      5'b01001: alu_uf = ($signed(alu_op1) < $signed(alu_op2));
      5'b10000: alu_r1 = alu_op1 * alu_op2;
      5'b10001: alu_r1 = (alu_op2 != 0) ? alu_op1 / alu_op2 : 32'd0;
      default: ;
    endcase
  end

  // Advance into the next cycle; inputs are driven just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_req(input logic n, input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] op);
    if (n == 1'b0) begin
      req0_valid = v; req0_op1 = a; req0_op2 = b; req0_aluop = op; req0_smt = 5'd0;
    end else begin
      req1_valid = v; req1_op1 = a; req1_op2 = b; req1_aluop = op; req1_smt = 5'd0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    sample();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (alu_op1 !== 32'd0) begin errors++; $display("FAIL reset_alu_op1: got %h expected 0", alu_op1); end
    checks++; if (alu_aluop !== 5'd0) begin errors++; $display("FAIL reset_alu_aluop: got %b expected 0", alu_aluop); end
    checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", {rsp0_valid, rsp1_valid}); end
    checks++; if (rsp0_r1 !== 32'd0 || rsp1_uf !== 1'b0) begin errors++; $display("FAIL reset_result: got %h/%b expected 0/0", rsp0_r1, rsp1_uf); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_single_add();
    cyc();
    drive_req(1'b0, 1'b1, 32'd5, 32'd7, 5'b00001);
    sample();
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL add_ready: got %b expected 10", {req0_ready, req1_ready}); end
    cyc();
    drive_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    sample();
    checks++; if (busy !== 1'b1 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL add_exec: got busy=%b rsp0=%b expected 1/0", busy, rsp0_valid); end
    cyc();
    sample();
    checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL add_rsp_valid: got %b%b expected 10", rsp0_valid, rsp1_valid); end
    checks++; if (rsp0_r1 !== 32'd12 || rsp0_uf !== 1'b0) begin errors++; $display("FAIL add_result: got %0d/%b expected 12/0", rsp0_r1, rsp0_uf); end
    cyc();
    sample();
    checks++; if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL add_done: got busy=%b rsp0=%b expected 0/0", busy, rsp0_valid); end
  endtask

  task automatic test_flags();
    logic [31:0] a_v[2]  = '{32'h7FFFFFFF, 32'd3};
    logic [31:0] b_v[2]  = '{32'd1, 32'd9};
    logic [4:0]  op_v[2] = '{5'b00001, 5'b01001};
    logic [31:0] r_e[2]  = '{32'h80000000, 32'd0};
    for (int i = 0; i < 2; i++) begin
      cyc();
      drive_req(1'b1, 1'b1, a_v[i], b_v[i], op_v[i]);
      sample();
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL flag%0d_ready: got %b expected 1", i, req1_ready); end
      cyc();
      drive_req(1'b1, 1'b0, 32'd0, 32'd0, 5'd0);
      cyc();
      sample();
      checks++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL flag%0d_valid: got %b%b expected 01", i, rsp0_valid, rsp1_valid); end
      checks++; if (rsp1_r1 !== r_e[i] || rsp1_uf !== 1'b1) begin errors++; $display("FAIL flag%0d_result: got %h/%b expected %h/1", i, rsp1_r1, rsp1_uf, r_e[i]); end
      cyc();
    end
  endtask

  task automatic test_arbitration();
    int order[4] = '{-1, -1, -1, -1};
    int n = 0;
    int both = 0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    drive_req(1'b0, 1'b1, 32'd1, 32'd1, 5'b00001);
    drive_req(1'b1, 1'b1, 32'd2, 32'd2, 5'b00001);
    for (int c = 0; c < 16; c++) begin
      sample();
      if (req0_ready && req1_ready) both++;
      if (n < 4 && req0_ready) begin order[n] = 0; n++; end
      else if (n < 4 && req1_ready) begin order[n] = 1; n++; end
      cyc();
    end
    drive_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    drive_req(1'b1, 1'b0, 32'd0, 32'd0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (order[i] !== (i % 2)) begin errors++; $display("FAIL arb_order%0d: got %0d expected %0d", i, order[i], i % 2); end
    end
    checks++; if (both !== 0) begin errors++; $display("FAIL arb_both_ready: got %0d cycles expected 0", both); end
    repeat (4) cyc();
  endtask

  task automatic test_mult();
    cyc();
    drive_req(1'b0, 1'b1, 32'd6, 32'd7, 5'b10000);
    sample();
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL mul_ready: got %b expected 1", req0_ready); end
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k == 1) drive_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      if (k == 2) drive_req(1'b1, 1'b1, 32'd2, 32'd2, 5'b00001);
      sample();
      checks++; if (alu_aluop !== 5'b10000 || busy !== 1'b1) begin errors++; $display("FAIL mul_hold_t%0d: got aluop=%b busy=%b expected 10000/1", k, alu_aluop, busy); end
      checks++; if (rsp0_valid !== (k == 5) || req1_ready !== 1'b0) begin errors++; $display("FAIL mul_timing_t%0d: got rsp0=%b rdy1=%b expected %b/0", k, rsp0_valid, req1_ready, (k == 5)); end
      if (k == 5) begin
        checks++; if (rsp0_r1 !== 32'd42) begin errors++; $display("FAIL mul_result: got %0d expected 42", rsp0_r1); end
      end
    end
    cyc();
    sample();
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL mul_next_ready: got %b expected 1", req1_ready); end
    cyc();
    drive_req(1'b1, 1'b0, 32'd0, 32'd0, 5'd0);
    cyc();
    sample();
    checks++; if (rsp1_valid !== 1'b1 || rsp1_r1 !== 32'd4) begin errors++; $display("FAIL mul_next_rsp: got %b/%0d expected 1/4", rsp1_valid, rsp1_r1); end
    cyc();
  endtask

  task automatic test_reset_mid_op();
    int pulses = 0;
    cyc();
    drive_req(1'b0, 1'b1, 32'd100, 32'd5, 5'b10001);
    sample();
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", req0_ready); end
    cyc();
    drive_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    sample();
    pulses += rsp0_valid;
    cyc();
    rst = 1'b1;
    drive_req(1'b1, 1'b1, 32'd1, 32'd2, 5'b00001);
    sample();
    pulses += rsp0_valid;
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL abort_exec_ready: got %b expected 0", req1_ready); end
    cyc();
    rst = 1'b0;
    sample();
    pulses += rsp0_valid;
    checks++; if (busy !== 1'b0 || alu_op1 !== 32'd0) begin errors++; $display("FAIL abort_cleared: got busy=%b op1=%h expected 0/0", busy, alu_op1); end
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL abort_req1_ready: got %b expected 1", req1_ready); end
    cyc();
    drive_req(1'b1, 1'b0, 32'd0, 32'd0, 5'd0);
    sample();
    pulses += rsp0_valid;
    cyc();
    sample();
    pulses += rsp0_valid;
    checks++; if (rsp1_valid !== 1'b1 || rsp1_r1 !== 32'd3) begin errors++; $display("FAIL abort_req1_rsp: got %b/%0d expected 1/3", rsp1_valid, rsp1_r1); end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_rsp0: got %0d pulses expected 0", pulses); end
    cyc();
  endtask

  task automatic test_withdraw();
    int rdy1 = 0;
    int rsp1 = 0;
    cyc();
    drive_req(1'b0, 1'b1, 32'd6, 32'd7, 5'b10000);
    sample();
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL wd_ready0: got %b expected 1", req0_ready); end
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k == 1) begin
        drive_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        drive_req(1'b1, 1'b1, 32'd9, 32'd9, 5'b00001);
      end
      if (k == 3) drive_req(1'b1, 1'b0, 32'd0, 32'd0, 5'd0);
      sample();
      rdy1 += req1_ready;
      rsp1 += rsp1_valid;
    end
    cyc();
    drive_req(1'b0, 1'b1, 32'd1, 32'd1, 5'b00001);
    drive_req(1'b1, 1'b1, 32'd3, 32'd3, 5'b00001);
    sample();
    checks++; if (rdy1 !== 0 || rsp1 !== 0) begin errors++; $display("FAIL wd_side_effect: got ready=%0d rsp=%0d expected 0/0", rdy1, rsp1); end
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL wd_prio: got %b expected 01", {req0_ready, req1_ready}); end
    cyc();
    drive_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    drive_req(1'b1, 1'b0, 32'd0, 32'd0, 5'd0);
    cyc();
    sample();
    checks++; if (rsp1_valid !== 1'b1 || rsp1_r1 !== 32'd6) begin errors++; $display("FAIL wd_rsp1: got %b/%0d expected 1/6", rsp1_valid, rsp1_r1); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_flags();
    test_arbitration();
    test_mult();
    test_reset_mid_op();
    test_withdraw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
